fpu_div_issue: RTL

FPU_DIV_ISSUE -- requirements
Module: fpu_div_issue

---
 rtl/fpu_pkg.sv | 6 +
 rtl/fdiv.sv | 55 +++++
 rtl/fpu_res_fifo.sv | 44 ++++
 rtl/fpu_div_issue.sv | 73 +++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared float32 type, divider latency default and canonical NaN.
package fpu_pkg;
    typedef logic [31:0] float32_t;
    localparam int FDIV_LAT = 4;
    localparam float32_t QNAN = 32'h7FC0_0000;
endpackage

// File: rtl/fdiv.sv
// fdiv: IEEE-754 single divide, round-to-nearest-even, subnormals flushed to zero.
// y trails x1/x2 by LAT-1 register stages; the caller's operand registers supply the first stage.
module fdiv import fpu_pkg::*; #(
    parameter int LAT = FDIV_LAT
) (
    input  logic     clk,
    input  float32_t x1,
    input  float32_t x2,
    output float32_t y
);
    logic [7:0] w_ea, w_eb;
    logic w_sign, w_za, w_zb, w_ia, w_ib, w_nan, w_grd, w_stk;
    logic [48:0] w_num, w_den;
    logic [25:0] w_q;
    logic [23:0] w_man;
    logic [24:0] w_rnd;
    logic signed [9:0] w_e;
    float32_t w_y;
    always_comb begin
        w_sign = x1[31] ^ x2[31];
        w_ea = x1[30:23];
        w_eb = x2[30:23];
        w_za = w_ea == 8'd0;
        w_zb = w_eb == 8'd0;
        w_ia = w_ea == 8'hFF;
        w_ib = w_eb == 8'hFF;
        w_nan = (w_ia && x1[22:0] != 23'd0) || (w_ib && x2[22:0] != 23'd0) || (w_za && w_zb) || (w_ia && w_ib);
        w_num = {1'b1, x1[22:0], 25'd0};
        w_den = {25'd0, 1'b1, x2[22:0]};
        w_q = 26'(w_num / w_den);
        // quotient lies in (2^24, 2^26): normalise to 24 bits plus guard and sticky
        w_man = w_q[25] ? w_q[25:2] : w_q[24:1];
        w_grd = w_q[25] ? w_q[1] : w_q[0];
        w_stk = (w_q[25] && w_q[0]) || (w_num % w_den != 49'd0);
        w_rnd = {1'b0, w_man} + 25'(w_grd && (w_stk || w_man[0]));
        w_e = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + 10'sd127
            - (w_q[25] ? 10'sd0 : 10'sd1) + (w_rnd[24] ? 10'sd1 : 10'sd0);
        w_y = w_nan ? QNAN
            : (w_ia || w_zb || w_e >= 10'sd255) ? {w_sign, 8'hFF, 23'd0}
            : (w_za || w_ib || w_e <= 10'sd0) ? {w_sign, 31'd0}
            : {w_sign, w_e[7:0], w_rnd[23] ? w_rnd[22:0] : 23'd0};
    end
    generate
        if (LAT > 1) begin : g_pipe
            float32_t r_p [LAT-1];
            always_ff @(posedge clk) begin
                r_p[0] <= w_y;
                for (int i = 1; i < LAT - 1; i++) r_p[i] <= r_p[i-1];
            end
            assign y = r_p[LAT-2];
        end else begin : g_comb
            assign y = w_y;
        end
    endgenerate
endmodule

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: result FIFO; push and pop may coincide at any fill level, clear empties it.
module fpu_res_fifo #(
    parameter int DEPTH = 8,
    parameter int W = 38
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         i_clr,
    input  logic                         i_push,
    input  logic [W-1:0]                 i_data,
    input  logic                         i_pop,
    output logic [W-1:0]                 o_data,
    output logic                         o_valid,
    output logic [$clog2(DEPTH+1)-1:0]   o_count
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic w_pop, w_full;
    assign o_valid = r_cnt != '0;
    assign o_count = r_cnt;
    assign o_data = o_valid ? r_mem[r_rp] : '0;
    assign w_pop = i_pop && o_valid;
    assign w_full = r_cnt == CW'(DEPTH);
    always_ff @(posedge clk)
        if (i_push && !i_clr) r_mem[r_wp] <= i_data;
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else if (i_clr) begin
            r_wp <= '0;
            r_rp <= '0;
            r_cnt <= '0;
        end else begin
            assert (!(i_push && w_full && !w_pop));
            if (i_push) r_wp <= (r_wp == AW'(DEPTH - 1)) ? '0 : r_wp + 1'b1;
            if (w_pop) r_rp <= (r_rp == AW'(DEPTH - 1)) ? '0 : r_rp + 1'b1;
            r_cnt <= r_cnt + CW'(i_push) - CW'(w_pop);
        end
endmodule

// File: rtl/fpu_div_issue.sv
// fpu_div_issue: credit-limited issue of divides into fdiv with an in-order result FIFO.
// Credits cover in-flight plus buffered results, so the FIFO can never overflow.
module fpu_div_issue import fpu_pkg::*; #(
    parameter int LAT = FDIV_LAT,
    parameter int DEPTH = 8,
    parameter int TAGW = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_x1,
    input  logic [31:0]     req_x2,
    input  logic [TAGW-1:0] req_tag,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [31:0]     res_y,
    output logic [TAGW-1:0] res_tag,
    output logic            busy
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] LIM = (CW + 1)'(DEPTH);
    float32_t r_x1, r_x2, w_y;
    logic [LAT-1:0] r_vld;
    logic [TAGW-1:0] r_tag [LAT];
    logic [CW-1:0] r_inflight, w_count;
    logic w_accept, w_pop;
    assign req_ready = !flush && ({1'b0, r_inflight} + {1'b0, w_count}) < LIM;
    assign w_accept = req_valid && req_ready;
    assign w_pop = res_valid && res_ready && !flush;
    assign busy = (r_inflight != '0) || (w_count != '0);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_x1 <= '0;
            r_x2 <= '0;
        end else if (w_accept) begin
            r_x1 <= req_x1;
            r_x2 <= req_x2;
        end
    // valid/tag pipe mirrors fdiv so the last stage lines up with y
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) begin
            r_vld <= '0;
            r_inflight <= '0;
            for (int i = 0; i < LAT; i++) r_tag[i] <= '0;
        end else begin
            r_vld[0] <= w_accept;
            r_tag[0] <= req_tag;
            for (int i = 1; i < LAT; i++) begin
                r_vld[i] <= r_vld[i-1] && !flush;
                r_tag[i] <= r_tag[i-1];
            end
            r_inflight <= flush ? '0 : r_inflight + CW'(w_accept) - CW'(r_vld[LAT-1]);
        end
    fdiv #(.LAT(LAT)) u_fdiv (
        .x1 (r_x1),
        .x2 (r_x2),
        .y  (w_y),
        .clk(clk)
    );
    fpu_res_fifo #(.DEPTH(DEPTH), .W(32 + TAGW)) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .i_clr  (flush),
        .i_push (r_vld[LAT-1]),
        .i_data ({w_y, r_tag[LAT-1]}),
        .i_pop  (w_pop),
        .o_data ({res_y, res_tag}),
        .o_valid(res_valid),
        .o_count(w_count)
    );
endmodule
